// File: rtl/lcd_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl_pkg
// Shared definitions for the character-LCD write sequencer: FSM state
// encoding, the HD44780 init command list, DDRAM line address bases and the
// command codes that need the long post-write wait.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_write_ctrl_pkg;

    // Sequencer states. PWRUP is only ever entered through reset.
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_EN_HI,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    // Width of the single shared delay counter; wide enough for the default
    // 15 ms power-up delay at 50 MHz.
    localparam int TIMER_W = 20;

    // Init command list, issued in this order with RS=0.
    localparam int         INIT_LEN      = 4;
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;

    // DDRAM address commands for the start of each display line.
    localparam logic [7:0] LINE0_ADDR = 8'h80;
    localparam logic [7:0] LINE1_ADDR = 8'hC0;

    // Commands that keep the panel busy for the long clear/home time.
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Init command for a given position in the init list.
    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = INIT_FUNC_SET;
            2'd1:    cmd = INIT_DISP_ON;
            2'd2:    cmd = INIT_CLEAR;
            default: cmd = INIT_ENTRY;
        endcase
        return cmd;
    endfunction

    // True when the written byte is a clear or home command, which needs
    // the long wait instead of the normal command wait.
    function automatic logic isLongCmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl_if
// Bundles the decoder-side character handshake, the clear request, the
// status flags and the LCD pin bus of the write sequencer.
//   master : the sequencer (drives char_ready, status and LCD pins)
//   slave  : the environment (drives char_valid, char_data, clear_req)
// Signals:
//   char_valid/char_data/char_ready : ASCII character handshake
//   clear_req                       : single-cycle clear request pulse
//   init_done, busy                 : sequencer status
//   lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data : panel pins
// ---------------------------------------------------------------------------
interface lcd_write_ctrl_if;

    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clear_req;
    logic       init_done;
    logic       busy;
    logic       lcd_on;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        input  char_valid,
        input  char_data,
        input  clear_req,
        output char_ready,
        output init_done,
        output busy,
        output lcd_on,
        output lcd_rs,
        output lcd_rw,
        output lcd_en,
        output lcd_data
    );

    modport slave (
        output char_valid,
        output char_data,
        output clear_req,
        input  char_ready,
        input  init_done,
        input  busy,
        input  lcd_on,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_en,
        input  lcd_data
    );

endinterface

// File: rtl/lcd_write_ctrl_delay_timer.sv
// ---------------------------------------------------------------------------
// lcd_delay_timer
// Loadable down-counter shared by the power-up, enable-high and post-write
// wait phases. Loading N makes done_o assert on the N-th cycle after the
// load, so a phase that loads on entry and leaves on done_o lasts N cycles.
// A count of zero means the timer is not running (idle_o).
// Ports:
//   clock, reset : system clock, async active-high reset (count clears to 0)
//   load_i       : load value_i this cycle (has priority over counting)
//   value_i      : reload value
//   done_o       : last cycle of the loaded delay
//   idle_o       : counter is at zero
// ---------------------------------------------------------------------------
module lcd_delay_timer #(
    parameter int W = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o,
    output logic         idle_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == W'(1));
    assign idle_o = (count_q == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl
// Write-only sequencer for an HD44780-class 2x16 character LCD in 8-bit
// mode. After a power-up delay it issues the init command list, then
// accepts ASCII characters over a valid/ready handshake and writes them
// with RS=1, inserting a DDRAM address command whenever a line fills.
// A sticky clear request is served from IDLE ahead of any character.
// Ports:
//   clock, reset : system clock, async active-high reset
//   bus          : lcd_write_ctrl_if master modport (handshake, clear
//                  request, status and LCD pins)
// Parameters:
//   POWERUP_CYC    : idle cycles after reset before the first init command
//                    (must be at least 2)
//   EN_HIGH_CYC    : cycles lcd_en is held high per write
//   CMD_WAIT_CYC   : cycles after EN falls before the next write
//   CLEAR_WAIT_CYC : post-write wait after a clear or home command
//   COLS           : characters per display line
// ---------------------------------------------------------------------------
module lcd_write_ctrl
    import lcd_write_ctrl_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned EN_HIGH_CYC    = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 82000,
    parameter int unsigned COLS           = 16
) (
    input logic               clock,
    input logic               reset,
    lcd_write_ctrl_if.master  bus
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    lcd_state_e         state_q, state_d;
    logic [1:0]         initIdx_q, initIdx_d;
    logic               initDone_q, initDone_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               en_q, en_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               line_q, line_d;
    logic               wrapPending_q, wrapPending_d;
    logic               clearPending_q, clearPending_d;

    logic               timerLoad;
    logic [TIMER_W-1:0] timerValue;
    logic               timerDone;
    logic               timerIdle;

    logic               clearPendingEff;
    logic               charReady;

    lcd_delay_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (timerLoad),
        .value_i (timerValue),
        .done_o  (timerDone),
        .idle_o  (timerIdle)
    );

    // A clear request arriving in the same cycle as a character must still
    // win, so the raw pulse is folded into the pending flag combinationally
    // before it gates char_ready.
    assign clearPendingEff = clearPending_q | bus.clear_req;
    assign charReady       = initDone_q & ~clearPendingEff & (state_q == ST_IDLE);

    // Next-state logic. Whenever the next state is LOAD the byte to be
    // written is chosen here, so RS and data are already on the bus during
    // the LOAD cycle and stay put until the following write is chosen.
    always_comb begin
        state_d        = state_q;
        initIdx_d      = initIdx_q;
        initDone_d     = initDone_q;
        rs_d           = rs_q;
        data_d         = data_q;
        col_d          = col_q;
        line_d         = line_q;
        wrapPending_d  = wrapPending_q;
        clearPending_d = clearPendingEff;
        timerLoad      = 1'b0;
        timerValue     = '0;

        case (state_q)
            ST_PWRUP: begin
                // The counter sits at zero out of reset; the first cycle
                // arms it, and that cycle is part of the power-up delay.
                if (timerIdle) begin
                    timerLoad  = 1'b1;
                    timerValue = TIMER_W'(POWERUP_CYC - 1);
                end else if (timerDone) begin
                    state_d   = ST_LOAD;
                    initIdx_d = 2'd0;
                    rs_d      = 1'b0;
                    data_d    = initCmd(2'd0);
                end
            end

            ST_LOAD: begin
                state_d = ST_SETUP;
            end

            ST_SETUP: begin
                state_d    = ST_EN_HI;
                timerLoad  = 1'b1;
                timerValue = TIMER_W'(EN_HIGH_CYC);
            end

            ST_EN_HI: begin
                if (timerDone) begin
                    state_d    = ST_WAIT;
                    timerLoad  = 1'b1;
                    timerValue = isLongCmd(rs_q, data_q) ? TIMER_W'(CLEAR_WAIT_CYC)
                                                         : TIMER_W'(CMD_WAIT_CYC);
                end
            end

            ST_WAIT: begin
                if (timerDone) begin
                    if (!initDone_q) begin
                        if (initIdx_q == 2'(INIT_LEN - 1)) begin
                            initDone_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            initIdx_d = initIdx_q + 1'b1;
                            state_d   = ST_LOAD;
                            rs_d      = 1'b0;
                            data_d    = initCmd(initIdx_q + 1'b1);
                        end
                    end else if (wrapPending_q) begin
                        // line_q already points at the new line.
                        wrapPending_d = 1'b0;
                        state_d       = ST_LOAD;
                        rs_d          = 1'b0;
                        data_d        = line_q ? LINE1_ADDR : LINE0_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                if (clearPendingEff) begin
                    state_d        = ST_LOAD;
                    rs_d           = 1'b0;
                    data_d         = CMD_CLEAR;
                    clearPending_d = 1'b0;
                    col_d          = '0;
                    line_d         = 1'b0;
                end else if (bus.char_valid) begin
                    state_d = ST_LOAD;
                    rs_d    = 1'b1;
                    data_d  = bus.char_data;
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d         = '0;
                        line_d        = ~line_q;
                        wrapPending_d = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_PWRUP;
            end
        endcase
    end

    // The enable strobe is registered so it is glitch-free and high exactly
    // while the sequencer is in EN_HI.
    assign en_d = (state_d == ST_EN_HI);

    // State and datapath registers; async reset drops lcd_en at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_PWRUP;
            initIdx_q      <= 2'd0;
            initDone_q     <= 1'b0;
            rs_q           <= 1'b0;
            data_q         <= 8'h00;
            en_q           <= 1'b0;
            col_q          <= '0;
            line_q         <= 1'b0;
            wrapPending_q  <= 1'b0;
            clearPending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            initIdx_q      <= initIdx_d;
            initDone_q     <= initDone_d;
            rs_q           <= rs_d;
            data_q         <= data_d;
            en_q           <= en_d;
            col_q          <= col_d;
            line_q         <= line_d;
            wrapPending_q  <= wrapPending_d;
            clearPending_q <= clearPending_d;
        end
    end

    assign bus.char_ready = charReady;
    assign bus.init_done  = initDone_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.lcd_on     = 1'b1;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_en     = en_q;
    assign bus.lcd_data   = data_q;

endmodule
